usb_ep_io_ctrl: RTL and testbench
=================================

Name: usb_ep_io_ctrl

Overview:
CPU-side controller that exposes one endpoint's TX and RX FIFOs on the 16-bit IO bus (slave side of if_io). It turns IO reads and writes into FIFO push, pop and flush requests, and keeps sticky error and status flags. It also generates a level interrupt. The block sits between the CPU IO bus and the endpoint FIFOs: it drives the write side of the TX FIFO (SIE reads it) and the read side of the RX FIFO (SIE writes it).

Parameters:
- base_addr, 16'h0000, IO base address; three consecutive word registers decoded at base_addr+0..2.
- addr_width, 4, FIFO usedw width; must be 4 for the STATUS packing below.
- data_width, 8, FIFO data width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- io_rd  in  1  IO read strobe, one cycle
- io_wr  in  1  IO write strobe, one cycle
- io_addr  in  16  IO address
- io_dout  in  16  write data from master
- io_din  out  16  read data to master
- tx_data  out  8  TX FIFO write data
- tx_wrreq  out  1  TX FIFO push
- tx_sclr  out  1  TX FIFO flush
- tx_usedw  in  4  TX FIFO fill level
- tx_empty  in  1  TX FIFO empty
- tx_full  in  1  TX FIFO full
- rx_q  in  8  RX FIFO show-ahead output
- rx_rdreq  out  1  RX FIFO pop
- rx_sclr  out  1  RX FIFO flush
- rx_usedw  in  4  RX FIFO fill level
- rx_empty  in  1  RX FIFO empty
- rx_full  in  1  RX FIFO full
- usb_reset  in  1  USB bus reset from transceiver
- irq  out  1  interrupt, level, active-high

Behaviour:
- Reset: all outputs 0; sticky flags 0; IRQ_EN 0; read-data register 0.
- Decode: a hit requires io_addr in base_addr..base_addr+2. Accesses to other addresses are ignored; io_din is unchanged.
- Simultaneous io_rd and io_wr in the same cycle: the write is serviced and the read is ignored.
- DATA (base+0) write in cycle N:
  - If tx_full=0 at N: tx_wrreq=1 and tx_data=io_dout[7:0] in cycle N+1 (registered, one-cycle pulse).
  - Else no push; TX_OVF sticky is set at N+1.
- DATA read in cycle N:
  - If rx_empty=0 at N: io_din={8'h00,rx_q} valid from N+1, and rx_rdreq pulses in N+1.
  - Else io_din=16'h0000 and RX_UNF sticky is set.
- io_din holds its value until the next decoded read. Back-to-back reads in N and N+1 are legal: the FIFO pops at N+1 and the next show-ahead value is sampled at N+1.
- STATUS (base+1) read, returned at N+1:
  - [3:0] rx_usedw
  - [7:4] tx_usedw
  - [8] rx_empty
  - [9] rx_full
  - [10] tx_empty
  - [11] tx_full
  - [12] TX_OVF
  - [13] RX_UNF
  - [14] USBRST
  - [15] 0
- STATUS write:
  - bit0=1: tx_sclr pulses one cycle at N+1.
  - bit1=1: rx_sclr pulses one cycle at N+1.
  - bits 12..14: write-1-to-clear the corresponding sticky.
- Sticky set vs clear in the same cycle: set wins.
- IRQ_EN (base+2): read/write, bits [2:0]; upper bits read 0.
- usb_reset: on its rising edge (detected internally, one register), tx_sclr and rx_sclr pulse together one cycle later and USBRST is set. A CPU push coincident with the flush pulse is lost and does not set TX_OVF.
- irq is registered: irq = (IRQ_EN[0] & ~rx_empty) | (IRQ_EN[1] & tx_empty) | (IRQ_EN[2] & (TX_OVF|RX_UNF|USBRST)). It updates one cycle after its inputs change.
- Counter widths: usedw values are passed through unmodified; a full FIFO with 16 entries reports usedw=0 with full=1, which is legal.
- Asynchronous reset mid-operation: any pending wrreq, rdreq or sclr pulse is dropped; nothing is replayed after reset.

Test Plan:
- Reset, then read STATUS with both FIFOs empty -> io_din=16'h0500; irq=0.
- Write DATA 16'h00A5 three times, then read STATUS -> three tx_wrreq pulses with tx_data=8'hA5, each one cycle after its write; STATUS[7:4]=3, STATUS[10]=0.
- Fill TX to full, then write DATA 16'h0011 -> no tx_wrreq; STATUS=16'h1800 with rx empty (bit8 also set, so 16'h1900). Write 16'h1000 to STATUS -> bit12 clears.
- RX FIFO holds 8'h3C,8'h7E; issue back-to-back DATA reads, then a third read -> io_din 16'h003C then 16'h007E with two rx_rdreq pulses; third read returns 16'h0000 and sets STATUS[13].
- Write IRQ_EN=3'b001, then the RX FIFO becomes non-empty -> irq=1 one cycle later; pop the last byte -> irq=0 one cycle after rx_empty rises.
- Pulse usb_reset while writing STATUS=16'h0001 -> exactly one tx_sclr pulse; rx_sclr pulses; STATUS[14]=1; irq asserts if IRQ_EN[2]=1.

Source files
------------

// File: rtl/usb_ep_io_ctrl_if.sv
// CPU IO bus as seen by one endpoint controller: one-cycle read/write
// strobes, a word address, write data from the CPU, and read data back.
interface usb_ep_io_ctrl_if;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [15:0] io_dout;
   logic [15:0] io_din;

   modport master (output io_rd, io_wr, io_addr, io_dout, input  io_din);
   modport slave  (input  io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/usb_ep_io_ctrl.sv
// Endpoint IO controller: maps the TX/RX FIFOs of one endpoint onto three
// IO words (DATA, STATUS, IRQ_EN). Every FIFO request is a registered,
// one-cycle pulse. Error and status flags are sticky, and the interrupt is
// a registered level output.
module usb_ep_io_ctrl #(
   parameter logic [15:0] base_addr  = 16'h0000,
   parameter int          addr_width = 4,   // STATUS packing assumes 4
   parameter int          data_width = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   usb_ep_io_ctrl_if.slave       io,
   output logic [data_width-1:0] tx_data,
   output logic                  tx_wrreq,
   output logic                  tx_sclr,
   input  logic [addr_width-1:0] tx_usedw,
   input  logic                  tx_empty,
   input  logic                  tx_full,
   input  logic [data_width-1:0] rx_q,
   output logic                  rx_rdreq,
   output logic                  rx_sclr,
   input  logic [addr_width-1:0] rx_usedw,
   input  logic                  rx_empty,
   input  logic                  rx_full,
   input  logic                  usb_reset,
   output logic                  irq
);

   localparam logic [1:0] SEL_DATA   = 2'd0;
   localparam logic [1:0] SEL_STATUS = 2'd1;
   localparam logic [1:0] SEL_IRQEN  = 2'd2;

   logic [data_width-1:0] tx_data_q, tx_data_d;
   logic                  tx_wrreq_q, tx_wrreq_d;
   logic                  tx_sclr_q, tx_sclr_d;
   logic                  rx_rdreq_q, rx_rdreq_d;
   logic                  rx_sclr_q, rx_sclr_d;
   logic [15:0]           din_q, din_d;
   logic                  tx_ovf_q, tx_ovf_d;
   logic                  rx_unf_q, rx_unf_d;
   logic                  usbrst_q, usbrst_d;
   logic [2:0]            irq_en_q, irq_en_d;
   logic                  irq_q, irq_d;
   logic                  usb_reset_q;

   logic [15:0] off;
   logic [1:0]  sel;
   logic        hit, wr_hit, rd_hit, usb_rise;
   logic        data_wr, stat_wr, data_rd;
   logic [15:0] status_word;

   // Address decode, strobe qualification (a write masks a coincident read)
   // and next-state for every register.
   always_comb begin
      off         = io.io_addr - base_addr;
      sel         = off[1:0];
      hit         = (off < 16'd3);
      wr_hit      = io.io_wr & hit;
      rd_hit      = io.io_rd & ~io.io_wr & hit;
      usb_rise    = usb_reset & ~usb_reset_q;
      data_wr     = wr_hit & (sel == SEL_DATA);
      stat_wr     = wr_hit & (sel == SEL_STATUS);
      data_rd     = rd_hit & (sel == SEL_DATA);
      status_word = {1'b0, usbrst_q, rx_unf_q, tx_ovf_q,
                     tx_full, tx_empty, rx_full, rx_empty, tx_usedw, rx_usedw};

      // A flush from either source lands in the same cycle as any push the
      // CPU issued alongside it; that push is dropped outright and is not
      // treated as an overflow.
      tx_sclr_d  = usb_rise | (stat_wr & io.io_dout[0]);
      rx_sclr_d  = usb_rise | (stat_wr & io.io_dout[1]);
      tx_wrreq_d = data_wr & ~tx_full & ~tx_sclr_d;
      tx_data_d  = data_wr ? io.io_dout[data_width-1:0] : tx_data_q;
      rx_rdreq_d = data_rd & ~rx_empty;

      // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
      tx_ovf_d = (data_wr & tx_full & ~tx_sclr_d) | (tx_ovf_q & ~(stat_wr & io.io_dout[12]));
      rx_unf_d = (data_rd & rx_empty)             | (rx_unf_q & ~(stat_wr & io.io_dout[13]));
      usbrst_d = usb_rise                         | (usbrst_q & ~(stat_wr & io.io_dout[14]));

      irq_en_d = (wr_hit & (sel == SEL_IRQEN)) ? io.io_dout[2:0] : irq_en_q;

      din_d = din_q;
      if (rd_hit) begin
         unique case (sel)
            SEL_DATA:   din_d = rx_empty ? 16'h0000 : {{(16-data_width){1'b0}}, rx_q};
            SEL_STATUS: din_d = status_word;
            SEL_IRQEN:  din_d = {13'h0000, irq_en_q};
            default:    din_d = din_q;
         endcase
      end

      irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty) |
              (irq_en_q[2] & (tx_ovf_q | rx_unf_q | usbrst_q));
   end

   // State and output registers; reset drops any pulse in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data_q   <= '0;
         tx_wrreq_q  <= 1'b0;
         tx_sclr_q   <= 1'b0;
         rx_rdreq_q  <= 1'b0;
         rx_sclr_q   <= 1'b0;
         din_q       <= 16'h0000;
         tx_ovf_q    <= 1'b0;
         rx_unf_q    <= 1'b0;
         usbrst_q    <= 1'b0;
         irq_en_q    <= 3'b000;
         irq_q       <= 1'b0;
         usb_reset_q <= 1'b0;
      end else begin
         tx_data_q   <= tx_data_d;
         tx_wrreq_q  <= tx_wrreq_d;
         tx_sclr_q   <= tx_sclr_d;
         rx_rdreq_q  <= rx_rdreq_d;
         rx_sclr_q   <= rx_sclr_d;
         din_q       <= din_d;
         tx_ovf_q    <= tx_ovf_d;
         rx_unf_q    <= rx_unf_d;
         usbrst_q    <= usbrst_d;
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
         usb_reset_q <= usb_reset;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_wrreq  = tx_wrreq_q;
   assign tx_sclr   = tx_sclr_q;
   assign rx_rdreq  = rx_rdreq_q;
   assign rx_sclr   = rx_sclr_q;
   assign io.io_din = din_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_usb_ep_io_ctrl.sv
// Bench for usb_ep_io_ctrl: behavioural TX/RX FIFOs around the DUT, directed
// IO accesses, and a scoreboard that checks FIFO pushes and read data as
// the DUT presents them.
module tb_usb_ep_io_ctrl;
   localparam logic [15:0] BASE = 16'h0040;
   localparam logic [15:0] A_DATA = BASE, A_STAT = BASE + 16'd1, A_IRQ = BASE + 16'd2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data, rx_q;
   logic       tx_wrreq, tx_sclr, rx_rdreq, rx_sclr, irq;
   logic [3:0] tx_usedw, rx_usedw;
   logic       tx_empty, tx_full, rx_empty, rx_full;
   logic       usb_reset = 1'b0;

   usb_ep_io_ctrl_if io();

   usb_ep_io_ctrl #(.base_addr(BASE), .addr_width(4), .data_width(8)) dut (
      .clk(clk), .reset_n(reset_n), .io(io),
      .tx_data(tx_data), .tx_wrreq(tx_wrreq), .tx_sclr(tx_sclr),
      .tx_usedw(tx_usedw), .tx_empty(tx_empty), .tx_full(tx_full),
      .rx_q(rx_q), .rx_rdreq(rx_rdreq), .rx_sclr(rx_sclr),
      .rx_usedw(rx_usedw), .rx_empty(rx_empty), .rx_full(rx_full),
      .usb_reset(usb_reset), .irq(irq)
   );

   always #5 clk = ~clk;

   // TX FIFO model: counts pushes, flush empties it.
   logic [4:0] tx_cnt = 5'd0;
   always @(posedge clk) begin
      if (tx_sclr)                          tx_cnt <= 5'd0;
      else if (tx_wrreq && tx_cnt < 5'd16)  tx_cnt <= tx_cnt + 5'd1;
   end
   assign tx_usedw = tx_cnt[3:0];
   assign tx_full  = (tx_cnt == 5'd16);
   assign tx_empty = (tx_cnt == 5'd0);

   // RX FIFO model, show-ahead: while a pop is in progress the output
   // already presents the following word, so back-to-back reads see it.
   logic [7:0] rx_mem [16];
   logic [3:0] rx_rd = 4'd0, rx_wr = 4'd0;
   logic [4:0] rx_cnt = 5'd0;
   logic       rx_push = 1'b0;
   logic [7:0] rx_push_data = 8'h00;
   always @(posedge clk) begin
      if (rx_sclr) begin
         rx_rd <= 4'd0; rx_wr <= 4'd0; rx_cnt <= 5'd0;
      end else begin
         if (rx_push) begin rx_mem[rx_wr] <= rx_push_data; rx_wr <= rx_wr + 4'd1; end
         if (rx_rdreq && rx_cnt != 5'd0) rx_rd <= rx_rd + 4'd1;
         rx_cnt <= rx_cnt + {4'd0, rx_push} - {4'd0, (rx_rdreq && rx_cnt != 5'd0)};
      end
   end
   always_comb begin
      rx_q     = rx_mem[rx_rd + {3'd0, rx_rdreq}];
      rx_empty = (rx_cnt == 5'd0) || (rx_cnt == 5'd1 && rx_rdreq);
      rx_full  = (rx_cnt == 5'd16);
      rx_usedw = rx_cnt[3:0];
   end

   int n_chk = 0, n_err = 0;
   int n_tx_sclr = 0, n_rx_sclr = 0, n_rdreq = 0;
   int e_tx_sclr = 0, e_rx_sclr = 0;
   logic [7:0]  exp_tx[$];
   logic [15:0] exp_din[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares each push and each decoded read result
   // against the queued expectation, and tallies flush/pop pulses.
   initial begin
      logic rd_seen;
      logic [15:0] e;
      forever begin
         @(posedge clk);
         rd_seen = reset_n && io.io_rd && !io.io_wr && ((io.io_addr - BASE) < 16'd3);
         @(negedge clk);
         if (tx_wrreq) begin
            if (exp_tx.size() == 0) chk("tx_push_unexpected", {8'h00, tx_data}, 16'hXXXX);
            else begin e = {8'h00, exp_tx.pop_front()}; chk("tx_data", {8'h00, tx_data}, e); end
         end
         if (rd_seen) begin
            if (exp_din.size() == 0) chk("rd_unexpected", io.io_din, 16'hXXXX);
            else begin e = exp_din.pop_front(); chk("io_din", io.io_din, e); end
         end
         if (tx_sclr)  n_tx_sclr++;
         if (rx_sclr)  n_rx_sclr++;
         if (rx_rdreq) n_rdreq++;
      end
   end

   // All tasks start and end 1 ns after a rising edge.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic io_write(input logic [15:0] a, input logic [15:0] d, input logic [7:0] push_exp, input bit push);
      if (push) exp_tx.push_back(push_exp);
      io.io_wr = 1'b1; io.io_addr = a; io.io_dout = d;
      @(posedge clk); #1;
      io.io_wr = 1'b0;
   endtask
   task automatic io_read(input logic [15:0] a, input logic [15:0] exp);
      exp_din.push_back(exp);
      io.io_rd = 1'b1; io.io_addr = a;
      @(posedge clk); #1;
      io.io_rd = 1'b0;
   endtask
   task automatic rx_load(input logic [7:0] b);
      rx_push = 1'b1; rx_push_data = b;
      @(posedge clk); #1;
      rx_push = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      io.io_rd = 1'b0; io.io_wr = 1'b0; io.io_addr = 16'h0000; io.io_dout = 16'h0000;
      #12;
      chk("rst_outs", {11'd0, tx_wrreq, tx_sclr, rx_rdreq, rx_sclr, irq}, 16'h0000);
      chk("rst_din", io.io_din, 16'h0000);
      chk("rst_txdata", {8'h00, tx_data}, 16'h0000);
      @(posedge clk); #1; reset_n = 1'b1;
      idle(1);

      // Idle status, interrupt quiet
      io_read(A_STAT, 16'h0500);
      idle(1);
      chk("irq_idle", {15'd0, irq}, 16'h0000);

      // Three pushes then fill level
      repeat (3) io_write(A_DATA, 16'h00A5, 8'hA5, 1'b1);
      idle(2);
      io_read(A_STAT, 16'h0130);

      // Fill to 16 entries, overflow write, clear TX_OVF, flush TX
      repeat (13) io_write(A_DATA, 16'h00A5, 8'hA5, 1'b1);
      idle(2);
      io_write(A_DATA, 16'h0011, 8'h00, 1'b0);
      idle(1);
      io_read(A_STAT, 16'h1900);
      io_write(A_STAT, 16'h1000, 8'h00, 1'b0);
      io_read(A_STAT, 16'h0900);
      io_write(A_STAT, 16'h0001, 8'h00, 1'b0); e_tx_sclr++;
      idle(1);
      io_read(A_STAT, 16'h0500);
      idle(1);
      chk("tx_sclr_cnt1", 16'(n_tx_sclr), 16'(e_tx_sclr));
      chk("rx_sclr_cnt1", 16'(n_rx_sclr), 16'(e_rx_sclr));

      // Back-to-back RX reads, then underflow
      rx_load(8'h3C);
      rx_load(8'h7E);
      io_read(A_DATA, 16'h003C);
      io_read(A_DATA, 16'h007E);
      io_read(A_DATA, 16'h0000);
      idle(2);
      chk("rdreq_cnt", 16'(n_rdreq), 16'd2);
      io_read(A_STAT, 16'h2500);
      io_write(A_STAT, 16'h2000, 8'h00, 1'b0);
      io_read(A_STAT, 16'h0500);

      // IRQ_EN register width and unmapped addresses leave io_din alone
      io_write(A_IRQ, 16'hFFF9, 8'h00, 1'b0);
      io_read(A_IRQ, 16'h0001);
      io.io_rd = 1'b1; io.io_addr = BASE + 16'd3; @(posedge clk); #1;
      io.io_addr = BASE - 16'd1; @(posedge clk); #1; io.io_rd = 1'b0;
      io_write(BASE + 16'd3, 16'h00EE, 8'h00, 1'b0);
      idle(1);
      chk("unmapped_din", io.io_din, 16'h0001);

      // RX-not-empty interrupt rises and falls one cycle after rx_empty
      chk("irq_rx_pre", {15'd0, irq}, 16'h0000);
      rx_load(8'h55);
      @(negedge clk); chk("irq_rx_lag", {15'd0, irq}, 16'h0000);
      @(negedge clk); chk("irq_rx_set", {15'd0, irq}, 16'h0001);
      @(posedge clk); #1;
      io_read(A_DATA, 16'h0055);
      @(negedge clk); chk("irq_rx_hold", {15'd0, irq}, 16'h0001);
      @(negedge clk); chk("irq_rx_clr", {15'd0, irq}, 16'h0000);
      @(posedge clk); #1;

      // USB reset coincident with a TX flush write: one merged pulse each
      io_write(A_IRQ, 16'h0004, 8'h00, 1'b0);
      usb_reset = 1'b1;
      io_write(A_STAT, 16'h0001, 8'h00, 1'b0); e_tx_sclr++; e_rx_sclr++;
      idle(3);
      chk("tx_sclr_cnt2", 16'(n_tx_sclr), 16'(e_tx_sclr));
      chk("rx_sclr_cnt2", 16'(n_rx_sclr), 16'(e_rx_sclr));
      io_read(A_STAT, 16'h4500);
      chk("irq_usbrst", {15'd0, irq}, 16'h0001);
      usb_reset = 1'b0;
      io_write(A_STAT, 16'h4000, 8'h00, 1'b0);
      idle(2);
      chk("irq_usbrst_clr", {15'd0, irq}, 16'h0000);
      io_read(A_STAT, 16'h0500);

      // USB reset coincident with a push: push lost, no TX_OVF
      usb_reset = 1'b1;
      io_write(A_DATA, 16'h0077, 8'h00, 1'b0); e_tx_sclr++; e_rx_sclr++;
      idle(2);
      usb_reset = 1'b0;
      io_read(A_STAT, 16'h4500);
      idle(1);
      chk("tx_sclr_cnt3", 16'(n_tx_sclr), 16'(e_tx_sclr));
      chk("rx_sclr_cnt3", 16'(n_rx_sclr), 16'(e_rx_sclr));

      // Async reset with a push pending: nothing emerges afterwards
      io.io_wr = 1'b1; io.io_addr = A_DATA; io.io_dout = 16'h0099;
      #2 reset_n = 1'b0;
      @(posedge clk); #1; io.io_wr = 1'b0;
      chk("arst_wrreq", {15'd0, tx_wrreq}, 16'h0000);
      chk("arst_din", io.io_din, 16'h0000);
      chk("arst_irq", {15'd0, irq}, 16'h0000);
      reset_n = 1'b1;
      idle(2);
      io_read(A_IRQ, 16'h0000);
      io_read(A_STAT, 16'h0500);
      idle(3);

      chk("sb_tx_drain", 16'(exp_tx.size()), 16'd0);
      chk("sb_din_drain", 16'(exp_din.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
